// File: rtl/pmu_event_shaper.sv
// ---------------------------------------------------------------------------
// pmu_event_shaper
//
// Per-tile event front end for the PMU counter array. Cores can report several
// occurrences of an event in one cycle, but each PMU counter only increments
// by at most one per cycle. This block adds each lane's increment to a small
// backlog accumulator and releases the backlog as single-cycle pulses, one per
// cycle per lane. If the backlog would exceed the accumulator range, the
// accumulator saturates and a sticky overflow flag records that counts were
// lost.
//
// Optional feature (macro PMU_EVENT_SHAPER_EDGE_EN):
//   When defined, the input edge_mode_i is added. A lane with edge_mode_i[e]=1
//   treats evt_inc_i bit 0 of that lane as a level and counts one event on each
//   0->1 transition. The upper increment bits of that lane are ignored. When the
//   macro is undefined, the port and the per-lane level flops do not exist.
//
// Ports
//   clk          counter clock
//   rst          synchronous, active-high reset
//   en_i         1: accept increments; 0: increments read as zero, backlog drains
//   flush_i      discard all backlog and same-cycle increments
//   clr_ovf_i    clear sticky overflow flags (a same-cycle overflow wins)
//   edge_mode_i  (macro only) per-lane edge-detect mode, static configuration
//   evt_inc_i    per-lane increment, lane e at [e*INC_WIDTH +: INC_WIDTH]
//   pmu_sig_o    per-lane count pulse, registered
//   ovf_o        per-lane sticky overflow, registered
//   pending_o    some lane still has a nonzero backlog, registered
//
// Interface semantics: there is no handshake. The counter array samples
// pmu_sig_o every cycle, and every cycle in which pmu_sig_o[e] is high
// represents exactly one event. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module pmu_event_shaper #(
  parameter int EVENT_SIGNAL_COUNT = 23,
  parameter int INC_WIDTH          = 2,
  parameter int ACC_WIDTH          = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en_i,
  input  logic                                     flush_i,
  input  logic                                     clr_ovf_i,
`ifdef PMU_EVENT_SHAPER_EDGE_EN
  input  logic [EVENT_SIGNAL_COUNT-1:0]            edge_mode_i,
`endif
  input  logic [EVENT_SIGNAL_COUNT*INC_WIDTH-1:0]  evt_inc_i,
  output logic [EVENT_SIGNAL_COUNT-1:0]            pmu_sig_o,
  output logic [EVENT_SIGNAL_COUNT-1:0]            ovf_o,
  output logic                                     pending_o
);

  localparam int N = EVENT_SIGNAL_COUNT;

  // The sum is computed one bit wider than the accumulator. Because
  // ACC_WIDTH >= INC_WIDTH, the largest possible sum fits without wrapping,
  // so saturation can be detected exactly.
  localparam logic [ACC_WIDTH:0] ACC_MAX_W = {1'b0, {ACC_WIDTH{1'b1}}};
  localparam logic [ACC_WIDTH:0] ONE_W     = {{ACC_WIDTH{1'b0}}, 1'b1};

  logic [ACC_WIDTH-1:0] acc_q   [N];
  logic [ACC_WIDTH-1:0] acc_d   [N];
  logic [INC_WIDTH-1:0] inc_eff [N];
  logic [ACC_WIDTH:0]   total   [N];
  logic [ACC_WIDTH:0]   rem     [N];
  logic [N-1:0]         sat_d;
  logic [N-1:0]         sig_d;
  logic [N-1:0]         ovf_d;
  logic [N-1:0]         nz_d;
  logic                 pending_d;

`ifdef PMU_EVENT_SHAPER_EDGE_EN
  // Previous level of bit 0 of each lane. It updates every cycle, independent
  // of en_i and flush_i, so edge detection never sees a stale level.
  logic [N-1:0] lvl_q;
  logic [N-1:0] lvl_now;

  always_comb begin
    lvl_now = '0;
    for (int e = 0; e < N; e++) begin
      lvl_now[e] = evt_inc_i[e*INC_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_now;
    end
  end
`endif

  // Select the effective increment for each lane.
  always_comb begin
    for (int e = 0; e < N; e++) begin
      inc_eff[e] = '0;
      if (en_i) begin
        inc_eff[e] = evt_inc_i[e*INC_WIDTH +: INC_WIDTH];
`ifdef PMU_EVENT_SHAPER_EDGE_EN
        if (edge_mode_i[e]) begin
          inc_eff[e]    = '0;
          inc_eff[e][0] = lvl_now[e] & ~lvl_q[e];
        end
`endif
      end
    end
  end

  // Accumulate, emit one pulse, and saturate.
  always_comb begin
    sat_d     = '0;
    sig_d     = '0;
    ovf_d     = '0;
    nz_d      = '0;
    pending_d = 1'b0;
    for (int e = 0; e < N; e++) begin
      total[e] = {1'b0, acc_q[e]}
               + {{(ACC_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_eff[e]};
      rem[e]   = '0;
      if (total[e] != '0) begin
        sig_d[e] = 1'b1;
        rem[e]   = total[e] - ONE_W;
      end
      sat_d[e] = (rem[e] > ACC_MAX_W);
      acc_d[e] = sat_d[e] ? {ACC_WIDTH{1'b1}} : rem[e][ACC_WIDTH-1:0];

      // Flush discards the backlog and this cycle's increment. Because the
      // increment is discarded, it is not counted as lost, so flush cannot
      // raise an overflow.
      if (flush_i) begin
        acc_d[e] = '0;
        sig_d[e] = 1'b0;
        sat_d[e] = 1'b0;
      end

      // A new overflow in this cycle takes priority over a clear.
      ovf_d[e] = sat_d[e] | (ovf_o[e] & ~clr_ovf_i);
      nz_d[e]  = (acc_d[e] != '0);
    end
    pending_d = |nz_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < N; e++) begin
        acc_q[e] <= '0;
      end
      pmu_sig_o <= '0;
      ovf_o     <= '0;
      pending_o <= 1'b0;
    end else begin
      for (int e = 0; e < N; e++) begin
        acc_q[e] <= acc_d[e];
      end
      pmu_sig_o <= sig_d;
      ovf_o     <= ovf_d;
      pending_o <= pending_d;
    end
  end

endmodule
